// File: rtl/freq_disp_ctrl.sv
// freq_disp_ctrl
// Sequences a 32-bit binary frequency count into 8 packed BCD digits using a
// serial shift-add-3 (double-dabble) engine. The result is loaded into the
// scanner's display word in one step. Counts above MAX_VAL are shown as
// all-F and flagged on overflow.
//
// Parameters:
//   POINT_LO  - digit index driven on point_1 (kHz separator)
//   POINT_HI  - value driven on point_2; the scanner adds 4 (MHz separator)
//   MAX_VAL   - largest count that is displayed as a number
//
// Ports:
//   Clk        in   1   system clock
//   Reset_n    in   1   asynchronous active-low reset
//   freq_in    in  32   binary frequency count (Hz)
//   freq_valid in   1   one-cycle strobe qualifying freq_in
//   hold       in   1   freeze request (only with FREQ_DISP_HOLD_EN)
//   Disp_Data  out 32   packed BCD, [3:0] = digit 0 (rightmost)
//   point_1    out  3   lower decimal-point digit select
//   point_2    out  3   upper decimal-point select
//   busy       out  1   conversion in progress
//   overflow   out  1   displayed value is an out-of-range result
//
// Optional feature macro: FREQ_DISP_HOLD_EN adds the hold input. While hold
// is high in IDLE, new strobes are ignored and the display stays frozen.

module freq_disp_ctrl #(
    parameter int unsigned POINT_LO = 3,
    parameter int unsigned POINT_HI = 2,
    parameter int unsigned MAX_VAL  = 99_999_999
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] freq_in,
    input  logic        freq_valid,
`ifdef FREQ_DISP_HOLD_EN
    input  logic        hold,
`endif
    output logic [31:0] Disp_Data,
    output logic [2:0]  point_1,
    output logic [2:0]  point_2,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned DW  = 32;
    localparam int unsigned NIB = DW / 4;
    localparam int unsigned CW  = 5;
    localparam int unsigned PW  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        CONV  = 2'd2,
        LOAD  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   bin, bin_nxt;
    logic [DW-1:0]   bcd, bcd_nxt;
    logic [DW-5:0]   bcd_adj_lo;
    logic [2:0]      bcd_adj_top;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            ovf_pend, ovf_pend_nxt;
    logic [DW-1:0]   disp_nxt;
    logic            ovf_nxt;
    logic            busy_nxt;
    logic            start;

    // Add-3 correction of one BCD nibble.
    function automatic logic [3:0] nib_adj(input logic [3:0] n);
        return (n >= 4'd5) ? 4'(n + 4'd3) : n;
    endfunction

`ifdef FREQ_DISP_HOLD_EN
    assign start = freq_valid && !hold;
`else
    assign start = freq_valid;
`endif

    // Parallel nibble correction ahead of the shift. The top nibble's carry
    // bit would be shifted out anyway; MAX_VAL keeps it zero for valid input.
    always_comb begin
        bcd_adj_lo = bcd[DW-5:0];
        for (int i = 0; i < int'(NIB) - 1; i++) begin
            bcd_adj_lo[4*i +: 4] = nib_adj(bcd[4*i +: 4]);
        end
        bcd_adj_top = 3'(nib_adj(bcd[DW-1 -: 4]));
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt    = state;
        bin_nxt      = bin;
        bcd_nxt      = bcd;
        cnt_nxt      = cnt;
        ovf_pend_nxt = ovf_pend;
        disp_nxt     = Disp_Data;
        ovf_nxt      = overflow;

        case (state)
            IDLE: begin
                if (start) begin
                    bin_nxt   = freq_in;
                    bcd_nxt   = '0;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (bin > DW'(MAX_VAL)) begin
                    bcd_nxt      = '1;
                    ovf_pend_nxt = 1'b1;
                    state_nxt    = LOAD;
                end else begin
                    ovf_pend_nxt = 1'b0;
                    cnt_nxt      = '0;
                    state_nxt    = CONV;
                end
            end
            CONV: begin
                bcd_nxt = {bcd_adj_top, bcd_adj_lo, bin[DW-1]};
                bin_nxt = {bin[DW-2:0], 1'b0};
                cnt_nxt = CW'(cnt + 1'b1);
                if (cnt == CW'(DW - 1)) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                disp_nxt  = bcd;
                ovf_nxt   = ovf_pend;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            bin       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            ovf_pend  <= 1'b0;
            Disp_Data <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            point_1   <= PW'(POINT_LO);
            point_2   <= PW'(POINT_HI);
        end else begin
            state     <= state_nxt;
            bin       <= bin_nxt;
            bcd       <= bcd_nxt;
            cnt       <= cnt_nxt;
            ovf_pend  <= ovf_pend_nxt;
            Disp_Data <= disp_nxt;
            overflow  <= ovf_nxt;
            busy      <= busy_nxt;
            point_1   <= PW'(POINT_LO);
            point_2   <= PW'(POINT_HI);
        end
    end

endmodule

// File: tb/tb_freq_disp_ctrl.sv
// tb_freq_disp_ctrl
// Self-checking bench for freq_disp_ctrl: directed boundary cases plus
// randomized counts, checked against a decimal-digit reference model.

module tb_freq_disp_ctrl;

    localparam logic [31:0] MAX_VAL = 32'd99_999_999;

    logic        Clk;
    logic        Reset_n;
    logic [31:0] freq_in;
    logic        freq_valid;
    logic        hold;
    logic [31:0] Disp_Data;
    logic [2:0]  point_1;
    logic [2:0]  point_2;
    logic        busy;
    logic        overflow;

    int          n_vec;
    int          n_err;
    logic [31:0] prev_disp;
    logic        prev_ovf;

    freq_disp_ctrl dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .freq_in    (freq_in),
        .freq_valid (freq_valid),
`ifdef FREQ_DISP_HOLD_EN
        .hold       (hold),
`endif
        .Disp_Data  (Disp_Data),
        .point_1    (point_1),
        .point_2    (point_2),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: decimal digits by repeated division, all-F when out of range.
    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r;
        logic [31:0] x;
        if (v > MAX_VAL) return 32'hFFFF_FFFF;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 32'd10);
            x = x / 32'd10;
        end
        return r;
    endfunction

    // One conversion: capture v at edge T, optionally pulse a stray strobe
    // before edge T+drop_at, optionally raise hold before edge T+hold_at.
    task automatic run_conv(input logic [31:0] v, input int drop_at, input int hold_at);
        logic [31:0] exp_d;
        logic        exp_o;
        exp_o = (v > MAX_VAL);
        exp_d = to_bcd(v);
        freq_in    = v;
        freq_valid = 1'b1;
        tick();
        freq_valid = 1'b0;
        freq_in    = $urandom;
        if (exp_o) begin
            tick();
            check("ovf_busy_t1", {31'd0, busy}, 32'd1);
            check("ovf_disp_t1", Disp_Data, prev_disp);
            tick();
            check("ovf_disp_t2", Disp_Data, exp_d);
            check("ovf_flag_t2", {31'd0, overflow}, 32'd1);
            check("ovf_busy_t2", {31'd0, busy}, 32'd0);
        end else begin
            for (int t = 1; t <= 34; t++) begin
                if (t == drop_at) begin
                    freq_valid = 1'b1;
                    freq_in    = $urandom;
                end
`ifdef FREQ_DISP_HOLD_EN
                if (t == hold_at) hold = 1'b1;
`endif
                tick();
                freq_valid = 1'b0;
                if (t == 1 || t == 33) check("conv_busy", {31'd0, busy}, 32'd1);
                if (t == 33) begin
                    check("conv_disp_stable", Disp_Data, prev_disp);
                    check("conv_ovf_stable", {31'd0, overflow}, {31'd0, prev_ovf});
                end
            end
            check("load_disp", Disp_Data, exp_d);
            check("load_ovf", {31'd0, overflow}, 32'd0);
            check("load_busy", {31'd0, busy}, 32'd0);
            if (drop_at >= 2) begin
                tick();
                check("drop_no_restart", {31'd0, busy}, 32'd0);
                check("drop_disp", Disp_Data, exp_d);
            end
        end
        prev_disp = exp_d;
        prev_ovf  = exp_o;
    endtask

    initial begin
        logic [31:0] v;
        int          sel;
        int          drop_at;

        n_vec      = 0;
        n_err      = 0;
        prev_disp  = '0;
        prev_ovf   = 1'b0;
        hold       = 1'b0;
        freq_in    = '0;
        freq_valid = 1'b0;
        Reset_n    = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (10) tick();

        check("rst_disp", Disp_Data, 32'd0);
        check("rst_p1", {29'd0, point_1}, 32'd3);
        check("rst_p2", {29'd0, point_2}, 32'd2);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        run_conv(32'd12_345_678, 0, 0);
        check("dir_12345678", Disp_Data, 32'h1234_5678);
        run_conv(32'd99_999_999, 0, 0);
        check("dir_max", Disp_Data, 32'h9999_9999);
        run_conv(32'd0, 0, 0);
        check("dir_zero", Disp_Data, 32'h0000_0000);
        run_conv(32'd100_000_000, 0, 0);
        check("dir_ovf_flag", {31'd0, overflow}, 32'd1);
        check("dir_ovf_p1", {29'd0, point_1}, 32'd3);
        run_conv(32'd7, 0, 0);
        check("dir_ovf_clear", {31'd0, overflow}, 32'd0);
        run_conv(32'd500, 10, 0);
        check("dir_drop_500", Disp_Data, 32'h0000_0500);
        run_conv(32'd31_415, 34, 0);

        for (int k = 0; k < 24; k++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       v = $urandom;
                1, 2:    v = $urandom_range(0, 99_999_999);
                default: v = $urandom_range(0, 9_999);
            endcase
            drop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 34)) : 0;
            run_conv(v, drop_at, 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset in the middle of a conversion of 4321.
        freq_in    = 32'd4_321;
        freq_valid = 1'b1;
        tick();
        freq_valid = 1'b0;
        repeat (15) tick();
        Reset_n = 1'b0;
        #1;
        check("midrst_disp", Disp_Data, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ovf", {31'd0, overflow}, 32'd0);
        #2;
        Reset_n   = 1'b1;
        prev_disp = '0;
        prev_ovf  = 1'b0;
        repeat (40) tick();
        check("midrst_noload", Disp_Data, 32'd0);
        check("midrst_idle", {31'd0, busy}, 32'd0);

        run_conv(32'd86_420, 0, 0);

`ifdef FREQ_DISP_HOLD_EN
        hold       = 1'b1;
        freq_in    = 32'd42;
        freq_valid = 1'b1;
        tick();
        freq_valid = 1'b0;
        repeat (3) tick();
        check("hold_busy", {31'd0, busy}, 32'd0);
        repeat (35) tick();
        check("hold_frozen", Disp_Data, prev_disp);
        hold = 1'b0;
        run_conv(32'd42, 0, 5);
        check("hold_late_load", Disp_Data, 32'h0000_0042);
        hold = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute guard so the run cannot hang.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
